// File: rtl/axis_pattern_src_pkg.sv
// Shared types and helpers for the AXI4-Stream pattern source.
package axis_pattern_src_pkg;

    localparam int unsigned TAPS_W = 32;

    // Burst sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    // Data pattern selected at launch
    typedef enum logic {
        PAT_INC  = 1'b0,
        PAT_LFSR = 1'b1
    } pat_e;

    // Galois feedback taps for each supported TDATA width
    function automatic logic [TAPS_W-1:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            default: return 32'h8020_0003;
        endcase
    endfunction

endpackage

// File: rtl/axis_pattern_src_gen.sv
// Next-data generator: incrementing count or right-shift Galois LFSR.
module axis_pattern_src_gen
    import axis_pattern_src_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  pat_e                  mode,
    input  logic [DATA_WIDTH-1:0] cur,
    output logic [DATA_WIDTH-1:0] nxt_c
);

    localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

    // Select the successor of cur for the active pattern
    always_comb begin
        nxt_c = cur + DATA_WIDTH'(1);
        if (mode == PAT_LFSR) begin
            if (cur[0]) begin
                nxt_c = (cur >> 1) ^ TAPS;
            end else begin
                nxt_c = cur >> 1;
            end
        end
    end

endmodule

// File: rtl/axis_pattern_src.sv
// AXI4-Stream master emitting a finite count/LFSR burst per start pulse.
// Optional TLAST framing is built when AXIS_SRC_TLAST_EN is defined.
module axis_pattern_src
    import axis_pattern_src_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  beat_cnt,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata
`ifdef AXIS_SRC_TLAST_EN
    ,
    output logic                  m_axis_tlast
`endif
);

    state_e                state_q;
    state_e                state_d;
    pat_e                  mode_q;
    pat_e                  mode_d;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  len_d;

    logic                  tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_d;
    logic                  busy_d;
    logic                  done_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_d;
`ifdef AXIS_SRC_TLAST_EN
    logic                  tlast_d;
`endif

    pat_e                  mode_in_c;
    logic [DATA_WIDTH-1:0] seed_eff_c;
    logic [DATA_WIDTH-1:0] gen_nxt_c;
    logic                  handshake_c;
    logic                  last_beat_c;

    // Launch-time decode and per-beat status
    always_comb begin
        mode_in_c   = pat_e'(mode);
        seed_eff_c  = seed;
        if ((mode_in_c == PAT_LFSR) && (seed == '0)) begin
            // An all-zero LFSR never leaves zero
            seed_eff_c = DATA_WIDTH'(1);
        end
        handshake_c = m_axis_tvalid & m_axis_tready;
        last_beat_c = ((beat_cnt + LEN_WIDTH'(1)) == len_q);
    end

    axis_pattern_src_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_gen (
        .mode  (mode_q),
        .cur   (m_axis_tdata),
        .nxt_c (gen_nxt_c)
    );

    // State register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (handshake_c && last_beat_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values for every registered output and burst context
    always_comb begin
        tvalid_d   = m_axis_tvalid;
        tdata_d    = m_axis_tdata;
        beat_cnt_d = beat_cnt;
        mode_d     = mode_q;
        len_d      = len_q;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
`ifdef AXIS_SRC_TLAST_EN
        tlast_d    = m_axis_tlast;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = mode_in_c;
                    len_d      = len;
                    beat_cnt_d = '0;
                    if (len != '0) begin
                        tvalid_d = 1'b1;
                        tdata_d  = seed_eff_c;
`ifdef AXIS_SRC_TLAST_EN
                        tlast_d  = (len == LEN_WIDTH'(1));
`endif
                    end
                end
            end
            SEND: begin
                if (handshake_c) begin
                    beat_cnt_d = beat_cnt + LEN_WIDTH'(1);
                    if (last_beat_c) begin
                        tvalid_d = 1'b0;
`ifdef AXIS_SRC_TLAST_EN
                        tlast_d  = 1'b0;
`endif
                    end else begin
                        tdata_d  = gen_nxt_c;
`ifdef AXIS_SRC_TLAST_EN
                        tlast_d  = ((beat_cnt + LEN_WIDTH'(2)) == len_q);
`endif
                    end
                end
            end
            default: begin
                tvalid_d = 1'b0;
            end
        endcase
    end

    // Output and context registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            beat_cnt      <= '0;
            mode_q        <= PAT_INC;
            len_q         <= '0;
`ifdef AXIS_SRC_TLAST_EN
            m_axis_tlast  <= 1'b0;
`endif
        end else begin
            m_axis_tvalid <= tvalid_d;
            m_axis_tdata  <= tdata_d;
            busy          <= busy_d;
            done          <= done_d;
            beat_cnt      <= beat_cnt_d;
            mode_q        <= mode_d;
            len_q         <= len_d;
`ifdef AXIS_SRC_TLAST_EN
            m_axis_tlast  <= tlast_d;
`endif
        end
    end

endmodule

// File: tb/tb_axis_pattern_src.sv
// Directed scoreboard bench for axis_pattern_src (8-bit data, 16-bit length).
module tb_axis_pattern_src;

    logic        aclk;
    logic        areset;
    logic        start;
    logic        mode;
    logic [7:0]  seed;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [15:0] beat_cnt;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tdata;
`ifdef AXIS_SRC_TLAST_EN
    logic        m_axis_tlast;
`endif

    int total = 0;
    int bad   = 0;

    logic [8:0] sb[$];
    bit         stall_pending = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    axis_pattern_src #(
        .DATA_WIDTH (8),
        .LEN_WIDTH  (16)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .mode          (mode),
        .seed          (seed),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .beat_cnt      (beat_cnt),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata)
`ifdef AXIS_SRC_TLAST_EN
        ,
        .m_axis_tlast  (m_axis_tlast)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_next(input bit m, input logic [7:0] x);
        if (!m) return x + 8'd1;
        if (x[0]) return (x >> 1) ^ 8'hB8;
        return x >> 1;
    endfunction

    task automatic push_burst(input bit m, input logic [7:0] s, input logic [15:0] l);
        logic [7:0] v;
        v = (m && (s == 8'h00)) ? 8'h01 : s;
        for (int i = 0; i < int'(l); i++) begin
            sb.push_back({(i == int'(l) - 1), v});
            v = model_next(m, v);
        end
    endtask

    // Observe the cycle ahead of the next edge, then advance to the next falling edge
    task automatic tick();
        logic [8:0] e;
        if (stall_pending) begin
            check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("stall_tdata", 32'(m_axis_tdata), 32'(held_data));
`ifdef AXIS_SRC_TLAST_EN
            check("stall_tlast", 32'(m_axis_tlast), 32'(held_last));
`endif
        end
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            check("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("beat_tdata", 32'(m_axis_tdata), 32'(e[7:0]));
`ifdef AXIS_SRC_TLAST_EN
                check("beat_tlast", 32'(m_axis_tlast), 32'(e[8]));
`endif
            end
        end
        stall_pending = !areset && m_axis_tvalid && !m_axis_tready;
        held_data     = m_axis_tdata;
`ifdef AXIS_SRC_TLAST_EN
        held_last     = m_axis_tlast;
`else
        held_last     = 1'b0;
`endif
        @(negedge aclk);
    endtask

    task automatic launch(input bit m, input logic [7:0] s, input logic [15:0] l);
        start = 1'b1;
        mode  = m;
        seed  = s;
        len   = l;
        push_burst(m, s, l);
        tick();
        start = 1'b0;
        mode  = ~m;
        seed  = 8'h5A;
        len   = 16'hFFFF;
    endtask

    task automatic wait_done(input string tag, input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    // Checks at the done pulse, then one cycle later back in IDLE
    task automatic finish(input string tag, input logic [15:0] exp_len);
        check({tag, "_beat_cnt"}, 32'(beat_cnt), 32'(exp_len));
        check({tag, "_tvalid_off"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_beat_hold"}, 32'(beat_cnt), 32'(exp_len));
    endtask

    initial begin
        int n;
        areset        = 1'b1;
        start         = 1'b0;
        mode          = 1'b0;
        seed          = 8'h00;
        len           = 16'd0;
        m_axis_tready = 1'b1;
        held_data     = 8'h00;
        held_last     = 1'b0;
        repeat (2) @(negedge aclk);

        // reset values
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
`ifdef AXIS_SRC_TLAST_EN
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
`endif
        areset = 1'b0;
        tick();

        // count mode with wrap, full throughput
        launch(1'b0, 8'hFE, 16'd4);
        check("t1_launch_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t1_launch_tdata", 32'(m_axis_tdata), 32'h0FE);
        wait_done("t1", 20, n);
        check("t1_cycles", 32'(n), 32'd4);
        finish("t1", 16'd4);

        // backpressure on the second beat
        launch(1'b0, 8'h10, 16'd3);
        tick();
        m_axis_tready = 1'b0;
        repeat (3) tick();
        check("t2_stall_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t2_stall_tdata", 32'(m_axis_tdata), 32'h011);
        check("t2_stall_cnt", 32'(beat_cnt), 32'd1);
        m_axis_tready = 1'b1;
        wait_done("t2", 20, n);
        check("t2_cycles", 32'(n), 32'd2);
        finish("t2", 16'd3);

        // LFSR with seed 1 and with the zero seed substitution
        launch(1'b1, 8'h01, 16'd3);
        check("t3a_launch_tdata", 32'(m_axis_tdata), 32'h001);
        tick();
        check("t3a_beat1", 32'(m_axis_tdata), 32'h0B8);
        tick();
        check("t3a_beat2", 32'(m_axis_tdata), 32'h05C);
        wait_done("t3a", 20, n);
        finish("t3a", 16'd3);
        launch(1'b1, 8'h00, 16'd3);
        check("t3b_launch_tdata", 32'(m_axis_tdata), 32'h001);
        wait_done("t3b", 20, n);
        finish("t3b", 16'd3);

        // zero-length burst
        launch(1'b0, 8'h77, 16'd0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t4_beat_cnt", 32'(beat_cnt), 32'd0);

        // start during the done cycle is ignored, then taken in IDLE
        start = 1'b1;
        mode  = 1'b0;
        seed  = 8'h30;
        len   = 16'd2;
        tick();
        check("t4_ignored_busy", 32'(busy), 32'd0);
        check("t4_ignored_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t4_ignored_done", 32'(done), 32'd0);
        push_burst(1'b0, 8'h30, 16'd2);
        tick();
        start = 1'b0;
        len   = 16'hFFFF;
        check("t4_late_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t4_late_tdata", 32'(m_axis_tdata), 32'h030);
        wait_done("t4", 20, n);
        check("t4_cycles", 32'(n), 32'd2);
        finish("t4", 16'd2);

        // start while sending is ignored
        launch(1'b0, 8'h20, 16'd3);
        tick();
        start = 1'b1;
        mode  = 1'b1;
        seed  = 8'h99;
        len   = 16'd7;
        tick();
        start = 1'b0;
        wait_done("t5a", 20, n);
        finish("t5a", 16'd3);

        // reset after two of five beats abandons the burst
        launch(1'b0, 8'h40, 16'd5);
        tick();
        tick();
        check("t5b_cnt_before", 32'(beat_cnt), 32'd2);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        sb.delete();
        check("t5b_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t5b_busy", 32'(busy), 32'd0);
        check("t5b_beat_cnt", 32'(beat_cnt), 32'd0);
        check("t5b_tdata", 32'(m_axis_tdata), 32'd0);
        check("t5b_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5b_no_done", 32'(done), 32'd0);
            check("t5b_no_valid", 32'(m_axis_tvalid), 32'd0);
        end

`ifdef AXIS_SRC_TLAST_EN
        // TLAST on the final beat, held through a stall
        launch(1'b0, 8'h50, 16'd3);
        check("t6_tlast_b0", 32'(m_axis_tlast), 32'd0);
        tick();
        check("t6_tlast_b1", 32'(m_axis_tlast), 32'd0);
        tick();
        m_axis_tready = 1'b0;
        check("t6_tlast_b2", 32'(m_axis_tlast), 32'd1);
        repeat (2) tick();
        check("t6_tlast_held", 32'(m_axis_tlast), 32'd1);
        m_axis_tready = 1'b1;
        wait_done("t6a", 20, n);
        check("t6_tlast_clear", 32'(m_axis_tlast), 32'd0);
        finish("t6a", 16'd3);
        launch(1'b0, 8'h60, 16'd1);
        check("t6_single_tlast", 32'(m_axis_tlast), 32'd1);
        check("t6_single_tdata", 32'(m_axis_tdata), 32'h060);
        wait_done("t6b", 20, n);
        check("t6b_cycles", 32'(n), 32'd1);
        finish("t6b", 16'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
